bird_launcher: RTL and testbench



---
 rtl/launcher_pkg.sv | 18 +
 rtl/launcher_frame_timer.sv | 37 +++
 rtl/bird_launcher.sv | 123 ++++++++++++
 tb/tb_bird_launcher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/launcher_pkg.sv
// Shared types and default tuning constants for the bird launcher.
package launcher_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCharging = 2'd1,
    StFlying   = 2'd2,
    StCooldown = 2'd3
  } launcher_state_e;

  localparam int unsigned MIN_POWER             = 2;
  localparam int unsigned MAX_POWER             = 15;
  localparam int unsigned FLIGHT_TIMEOUT_FRAMES = 90;
  localparam int unsigned COOLDOWN_FRAMES       = 15;

  localparam int unsigned FrameCntW = 7;

endpackage

// File: rtl/launcher_frame_timer.sv
// Saturating frame counter; done fires on the tick that brings the count up to limit.
module launcher_frame_timer
  import launcher_pkg::FrameCntW;
(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [FrameCntW-1:0] limit,
  output logic                 done
);

  logic [FrameCntW-1:0] count_q, count_d, count_inc;

  assign count_inc = (count_q == {FrameCntW{1'b1}}) ? count_q : count_q + 1'b1;

  // done must not depend on clear: the owner derives clear from its next state.
  assign done = tick & (count_inc >= limit);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bird_launcher.sv
// Launcher FSM: charge on a fresh fire press, shoot on release, time the flight, cool down.
module bird_launcher #(
  parameter int unsigned MIN_POWER             = launcher_pkg::MIN_POWER,
  parameter int unsigned MAX_POWER             = launcher_pkg::MAX_POWER,
  parameter int unsigned FLIGHT_TIMEOUT_FRAMES = launcher_pkg::FLIGHT_TIMEOUT_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES       = launcher_pkg::COOLDOWN_FRAMES
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       newLevelPulse,
  input  logic       fire_key,
  input  logic [3:0] birdsLeft,
  input  logic       collisionBird,
  output logic       shoot_bird_pulse,
  output logic [3:0] launchPower,
  output logic       birdInFlight,
  output logic [1:0] launcherState
);

  import launcher_pkg::launcher_state_e;
  import launcher_pkg::StIdle;
  import launcher_pkg::StCharging;
  import launcher_pkg::StFlying;
  import launcher_pkg::StCooldown;
  import launcher_pkg::FrameCntW;

  localparam logic [3:0]           MinPower  = 4'(MIN_POWER);
  localparam logic [3:0]           MaxPower  = 4'(MAX_POWER);
  localparam logic [FrameCntW-1:0] FlightLim = FrameCntW'(FLIGHT_TIMEOUT_FRAMES);
  localparam logic [FrameCntW-1:0] CoolLim   = FrameCntW'(COOLDOWN_FRAMES);

  launcher_state_e      state_q, state_d;
  logic [3:0]           power_q, power_d;
  logic                 shoot_q, shoot_d;
  logic                 flight_q;
  logic                 fire_q;
  logic                 seen_low_q, seen_low_d;
  logic                 rise, abort;
  logic                 timer_clear, timer_done;
  logic [FrameCntW-1:0] timer_limit;

  // A key already held when reset releases is not a fresh press until it has been seen low.
  assign seen_low_d = seen_low_q | ~fire_key;
  assign rise       = fire_key & ~fire_q & seen_low_q;
  assign abort      = ~startGame | newLevelPulse;

  always_comb begin
    state_d = state_q;
    power_d = power_q;
    shoot_d = 1'b0;
    if (abort) begin
      state_d = StIdle;
      power_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise && (birdsLeft != 4'd0)) begin
            state_d = StCharging;
            power_d = MinPower;
          end
        end
        StCharging: begin
          if (!fire_key) begin
            state_d = StFlying;
            shoot_d = 1'b1;
          end else if (startOfFrame && (power_q < MaxPower)) begin
            power_d = power_q + 4'd1;
          end
        end
        StFlying: begin
          if (collisionBird || timer_done) begin
            state_d = StCooldown;
          end
        end
        StCooldown: begin
          if (timer_done) begin
            state_d = StIdle;
            power_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign timer_limit = (state_q == StCooldown) ? CoolLim : FlightLim;
  assign timer_clear = (state_d != state_q) || (state_q == StIdle) || (state_q == StCharging);

  launcher_frame_timer u_frame_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (timer_clear),
    .tick   (startOfFrame),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StIdle;
      power_q    <= '0;
      shoot_q    <= 1'b0;
      flight_q   <= 1'b0;
      fire_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      power_q    <= power_d;
      shoot_q    <= shoot_d;
      flight_q   <= (state_d == StFlying);
      fire_q     <= fire_key;
      seen_low_q <= seen_low_d;
    end
  end

  assign shoot_bird_pulse = shoot_q;
  assign launchPower      = power_q;
  assign birdInFlight     = flight_q;
  assign launcherState    = state_q;

endmodule

// File: tb/tb_bird_launcher.sv
// Self-checking bench for bird_launcher: vector table plus multi-cycle scenario sequences.
module tb_bird_launcher;

  localparam int SI = 0;
  localparam int SC = 1;
  localparam int SF = 2;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic       start = 1'b0;
  logic       nlp = 1'b0;
  logic       fire = 1'b0;
  logic       coll = 1'b0;
  logic [3:0] birds = 4'd0;
  logic       shoot;
  logic [3:0] power;
  logic       flight;
  logic [1:0] lstate;

  always #5 clk = ~clk;

  bird_launcher dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (sof),
    .startGame        (start),
    .newLevelPulse    (nlp),
    .fire_key         (fire),
    .birdsLeft        (birds),
    .collisionBird    (coll),
    .shoot_bird_pulse (shoot),
    .launchPower      (power),
    .birdInFlight     (flight),
    .launcherState    (lstate)
  );

  typedef struct {
    logic       sof, start, nlp, fire, coll;
    logic [3:0] birds;
    logic [1:0] st;
    logic [3:0] pw;
    logic       sh, fl;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [3:0] pw;
    logic       sh, fl;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[16];

  function automatic vec_t mk(int s, int g, int n, int f, int c, int b,
                              int st, int pw, int sh, int fl);
    vec_t v;
    v.sof = (s != 0); v.start = (g != 0); v.nlp = (n != 0); v.fire = (f != 0);
    v.coll = (c != 0); v.birds = 4'(b); v.st = 2'(st); v.pw = 4'(pw);
    v.sh = (sh != 0); v.fl = (fl != 0);
    return v;
  endfunction

  task automatic check_out();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got no expected entry, want one queued");
      return;
    end
    e = exp_q.pop_front();
    if (lstate !== e.st || power !== e.pw || shoot !== e.sh || flight !== e.fl) begin
      errors++;
      $display("FAIL %s: got state=%0d power=%0d shoot=%b flight=%b, want state=%0d power=%0d shoot=%b flight=%b",
               e.tag, lstate, power, shoot, flight, e.st, e.pw, e.sh, e.fl);
    end
  endtask

  task automatic push_exp(int st, int pw, int sh, int fl, string tag);
    exp_t e;
    e.st = 2'(st); e.pw = 4'(pw); e.sh = (sh != 0); e.fl = (fl != 0); e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    sof = v.sof; start = v.start; nlp = v.nlp; fire = v.fire; coll = v.coll; birds = v.birds;
    push_exp(int'(v.st), int'(v.pw), int'(v.sh), int'(v.fl), tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // One cycle with the current startGame/birdsLeft and no level pulse.
  task automatic cyc(int s, int f, int c, int st, int pw, int sh, int fl, string tag);
    apply(mk(s, int'(start), 0, f, c, int'(birds), st, pw, sh, fl), tag);
  endtask

  task automatic async_reset(int f_hold, string tag);
    @(negedge clk);
    #2;
    resetN = 1'b0;
    fire = (f_hold != 0); sof = 1'b0; coll = 1'b0; nlp = 1'b0;
    #1;
    push_exp(SI, 0, 0, 0, tag);
    check_out();
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          sof st nlp fi co bird  st  pw sh fl
    tbl[0]  = mk(0, 1, 0, 0, 0, 10, SI, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 10, SI, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 10, SI, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 0,  0, SI, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 10, SI, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 1, 10, SI, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 1, 0, 10, SC, 2, 0, 0);
    tbl[7]  = mk(1, 1, 0, 1, 0, 10, SC, 3, 0, 0);
    tbl[8]  = mk(0, 1, 0, 1, 1, 10, SC, 3, 0, 0);
    tbl[9]  = mk(1, 1, 0, 1, 0, 10, SC, 4, 0, 0);
    tbl[10] = mk(1, 1, 0, 1, 0, 10, SC, 5, 0, 0);
    tbl[11] = mk(1, 1, 0, 1, 0, 10, SC, 6, 0, 0);
    tbl[12] = mk(1, 1, 0, 1, 0, 10, SC, 7, 0, 0);
    tbl[13] = mk(1, 1, 0, 0, 0, 10, SF, 7, 1, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 10, SF, 7, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 10, SF, 7, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    push_exp(SI, 0, 0, 0, "reset_state");
    check_out();
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: 90th flight frame with a coincident collision -> one transition.
    for (int i = 1; i <= 89; i++) cyc(1, 0, 0, SF, 7, 0, 1, $sformatf("flight_f%0d", i));
    cyc(0, 0, 0, SF, 7, 0, 1, "flight_gap");
    cyc(1, 0, 1, SD, 7, 0, 0, "timeout_and_collision");
    cyc(0, 1, 0, SD, 7, 0, 0, "press_in_cooldown");
    cyc(1, 1, 1, SD, 7, 0, 0, "cool_f1_collision_ignored");
    for (int i = 2; i <= 14; i++) cyc(1, 1, 0, SD, 7, 0, 0, $sformatf("cool_f%0d", i));
    cyc(1, 1, 0, SI, 0, 0, 0, "cool_done");
    cyc(0, 1, 0, SI, 0, 0, 0, "held_no_recharge_a");
    cyc(1, 1, 0, SI, 0, 0, 0, "held_no_recharge_b");
    cyc(0, 0, 0, SI, 0, 0, 0, "release_idle");

    // Saturation, then collision at flight frame 10 with the key re-pressed.
    cyc(0, 1, 0, SC, 2, 0, 0, "sat_press");
    for (int i = 1; i <= 20; i++)
      cyc(1, 1, 0, SC, (2 + i > 15) ? 15 : 2 + i, 0, 0, $sformatf("sat_f%0d", i));
    cyc(0, 0, 0, SF, 15, 1, 1, "sat_release");
    cyc(0, 1, 0, SF, 15, 0, 1, "press_in_flight");
    for (int i = 1; i <= 9; i++) cyc(1, 1, 0, SF, 15, 0, 1, $sformatf("coll_f%0d", i));
    cyc(1, 1, 1, SD, 15, 0, 0, "collision_f10");
    for (int i = 1; i <= 14; i++) cyc(1, 1, 0, SD, 15, 0, 0, $sformatf("cool2_f%0d", i));
    cyc(1, 1, 0, SI, 0, 0, 0, "cool2_done");
    cyc(0, 1, 0, SI, 0, 0, 0, "held_no_recharge_c");
    cyc(0, 0, 0, SI, 0, 0, 0, "release_idle2");

    // startGame dropped together with release while charging.
    cyc(0, 1, 0, SC, 2, 0, 0, "blk_press");
    cyc(1, 1, 0, SC, 3, 0, 0, "blk_frame");
    apply(mk(0, 0, 0, 0, 0, 10, SI, 0, 0, 0), "blk_start_low_release");
    apply(mk(0, 0, 0, 0, 0, 10, SI, 0, 0, 0), "blk_no_late_pulse");
    apply(mk(0, 1, 0, 0, 0, 10, SI, 0, 0, 0), "blk_start_back");

    // newLevelPulse while charging and while flying.
    cyc(0, 1, 0, SC, 2, 0, 0, "nl_press");
    apply(mk(0, 1, 1, 1, 0, 10, SI, 0, 0, 0), "nl_in_charge");
    cyc(0, 1, 0, SI, 0, 0, 0, "nl_held");
    cyc(0, 0, 0, SI, 0, 0, 0, "nl_release");
    cyc(0, 1, 0, SC, 2, 0, 0, "nlf_press");
    cyc(0, 0, 0, SF, 2, 1, 1, "nlf_release");
    cyc(1, 0, 0, SF, 2, 0, 1, "nlf_frame");
    apply(mk(0, 1, 1, 0, 0, 10, SI, 0, 0, 0), "nl_in_flight");
    cyc(0, 0, 0, SI, 0, 0, 0, "nl_after");

    // startGame low while flying.
    cyc(0, 1, 0, SC, 2, 0, 0, "sg_press");
    cyc(0, 0, 0, SF, 2, 1, 1, "sg_release");
    apply(mk(0, 0, 0, 0, 0, 10, SI, 0, 0, 0), "sg_low_in_flight");
    apply(mk(0, 1, 0, 0, 0, 10, SI, 0, 0, 0), "sg_back");

    // Asynchronous reset mid-charge, then mid-flight with the key held across release.
    cyc(0, 1, 0, SC, 2, 0, 0, "rc_press");
    cyc(1, 1, 0, SC, 3, 0, 0, "rc_frame");
    async_reset(0, "reset_mid_charge");
    cyc(0, 0, 0, SI, 0, 0, 0, "rc_after");
    cyc(0, 1, 0, SC, 2, 0, 0, "rf_press");
    cyc(0, 0, 0, SF, 2, 1, 1, "rf_release");
    cyc(1, 0, 0, SF, 2, 0, 1, "rf_frame");
    async_reset(1, "reset_mid_flight");
    cyc(0, 1, 0, SI, 0, 0, 0, "held_after_reset_a");
    cyc(1, 1, 0, SI, 0, 0, 0, "held_after_reset_b");
    cyc(0, 0, 0, SI, 0, 0, 0, "release_after_reset");
    cyc(0, 1, 0, SC, 2, 0, 0, "fresh_press");
    cyc(0, 0, 0, SF, 2, 1, 1, "fresh_release");
    cyc(0, 0, 0, SF, 2, 0, 1, "fresh_single_pulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
